// File: rtl/universal_shift_reg_if.sv
// Data-side bundle of the universal shift register: load data, opcode,
// serial-in bits and the registered output.
interface universal_shift_reg_if #(
    parameter int N = 8
);
    localparam int SW = $clog2(N);

    logic [N-1:0]  D;
    logic [SW-1:0] S;
    logic          MSBin;
    logic          LSBin;
    logic [N-1:0]  Q;

    modport master (
        output D,
        output S,
        output MSBin,
        output LSBin,
        input  Q
    );

    modport slave (
        input  D,
        input  S,
        input  MSBin,
        input  LSBin,
        output Q
    );
endinterface

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register: hold, load, and logical/rotate/arithmetic
// shifts in both directions, selected each clock by the low three opcode bits.
module universal_shift_reg #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    universal_shift_reg_if.slave bus
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_LSR  = 3'd2,
        OP_LSL  = 3'd3,
        OP_RR   = 3'd4,
        OP_RL   = 3'd5,
        OP_ASR  = 3'd6,
        OP_ASL  = 3'd7
    } opcode_e;

    logic [N-1:0] qReg;
    logic [N-1:0] qNext;
    opcode_e      op;

    // Opcode bits above [2] only exist for wider registers and carry no meaning.
    assign op = opcode_e'(bus.S[2:0]);

    always_comb begin
        qNext = qReg;
        case (op)
            OP_NOP:  qNext = qReg;
            OP_LOAD: qNext = bus.D;
            OP_LSR:  qNext = {bus.MSBin, qReg[N-1:1]};
            OP_LSL:  qNext = {qReg[N-2:0], bus.LSBin};
            OP_RR:   qNext = {qReg[0], qReg[N-1:1]};
            OP_RL:   qNext = {qReg[N-2:0], qReg[N-1]};
            OP_ASR:  qNext = {qReg[N-1], qReg[N-1:1]};
            OP_ASL:  qNext = {qReg[N-2:0], 1'b0};
            default: qNext = qReg;
        endcase
    end

    // Clear is asynchronous and overrides every opcode while low.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            qReg <= '0;
        end else begin
            qReg <= qNext;
        end
    end

    assign bus.Q = qReg;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg (N=8): stimulus queues expected Q,
// a monitor compares after every rising edge.
module tb_universal_shift_reg;

    logic clk;
    logic clear;

    universal_shift_reg_if #(.N(8)) bus ();

    universal_shift_reg #(.N(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    int          checkCount;
    int          failCount;
    logic [7:0]  expQueue[$];
    string       nameQueue[$];
    logic [7:0]  modelQ;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: Q=%h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] modelNext(input logic [7:0] q, input logic [2:0] op,
                                             input logic [7:0] d, input logic msb, input logic lsb);
        logic [7:0] r;
        case (op)
            3'd0: r = q;
            3'd1: r = d;
            3'd2: r = {msb, q[7:1]};
            3'd3: r = {q[6:0], lsb};
            3'd4: r = {q[0], q[7:1]};
            3'd5: r = {q[6:0], q[7]};
            3'd6: r = {q[7], q[7:1]};
            default: r = {q[6:0], 1'b0};
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the Q expected after the next rise.
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [7:0] d,
                                 input logic msb, input logic lsb, input logic [7:0] expected);
        @(negedge clk);
        bus.S     = op;
        bus.D     = d;
        bus.MSBin = msb;
        bus.LSBin = lsb;
        expQueue.push_back(expected);
        nameQueue.push_back(name);
        modelQ = expected;
        @(posedge clk);
    endtask

    initial begin : monitor
        logic [7:0] e;
        string      n;
        forever begin
            @(posedge clk);
            #1;
            if (expQueue.size() > 0) begin
                e = expQueue.pop_front();
                n = nameQueue.pop_front();
                checkOutput(n, bus.Q, e);
            end
        end
    end

    initial begin : stimulus
        logic [2:0] rop;
        logic [7:0] rd;
        logic       rmsb;
        logic       rlsb;
        int         waitCycles;

        checkCount = 0;
        failCount  = 0;
        modelQ     = 8'h00;
        clear      = 1'b1;
        bus.S      = 3'd1;
        bus.D      = 8'h5A;
        bus.MSBin  = 1'b0;
        bus.LSBin  = 1'b0;

        #2 clear = 1'b0;
        #1 checkOutput("resetAsync", bus.Q, 8'h00);

        // Clear held low: every opcode must leave Q at zero.
        for (int i = 0; i < 8; i++) begin
            applyStimulus("resetHold", 3'(i), 8'hFF - 8'(i), i[0], ~i[0], 8'h00);
        end

        @(negedge clk);
        clear = 1'b1;

        applyStimulus("load", 3'd1, 8'hE5, 1'b0, 1'b0, 8'hE5);
        applyStimulus("nop",  3'd0, 8'hAA, 1'b1, 1'b1, 8'hE5);

        applyStimulus("load", 3'd1, 8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus("lsr1", 3'd2, 8'hFF, 1'b1, 1'b0, 8'h80);
        applyStimulus("lsr2", 3'd2, 8'hFF, 1'b1, 1'b0, 8'hC0);
        applyStimulus("lsr3", 3'd2, 8'hFF, 1'b0, 1'b1, 8'h60);
        applyStimulus("load", 3'd1, 8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus("lsl1", 3'd3, 8'hFF, 1'b0, 1'b1, 8'h01);
        applyStimulus("lsl2", 3'd3, 8'hFF, 1'b0, 1'b1, 8'h03);
        applyStimulus("lsl3", 3'd3, 8'hFF, 1'b1, 1'b0, 8'h06);

        applyStimulus("load", 3'd1, 8'h1B, 1'b0, 1'b0, 8'h1B);
        applyStimulus("rr1",  3'd4, 8'h00, 1'b0, 1'b0, 8'h8D);
        applyStimulus("rr2",  3'd4, 8'h00, 1'b0, 1'b0, 8'hC6);
        applyStimulus("load", 3'd1, 8'h1B, 1'b0, 1'b0, 8'h1B);
        applyStimulus("rl1",  3'd5, 8'h00, 1'b1, 1'b1, 8'h36);
        applyStimulus("rl2",  3'd5, 8'h00, 1'b1, 1'b1, 8'h6C);

        applyStimulus("load", 3'd1, 8'h1B, 1'b0, 1'b0, 8'h1B);
        applyStimulus("rr8",  3'd4, 8'h00, 1'b1, 1'b1, 8'h8D);
        applyStimulus("rr8",  3'd4, 8'h00, 1'b1, 1'b1, 8'hC6);
        applyStimulus("rr8",  3'd4, 8'h00, 1'b1, 1'b1, 8'h63);
        applyStimulus("rr8",  3'd4, 8'h00, 1'b1, 1'b1, 8'hB1);
        applyStimulus("rr8",  3'd4, 8'h00, 1'b1, 1'b1, 8'hD8);
        applyStimulus("rr8",  3'd4, 8'h00, 1'b1, 1'b1, 8'h6C);
        applyStimulus("rr8",  3'd4, 8'h00, 1'b1, 1'b1, 8'h36);
        applyStimulus("rr8",  3'd4, 8'h00, 1'b1, 1'b1, 8'h1B);
        applyStimulus("rl8",  3'd5, 8'h00, 1'b0, 1'b0, 8'h36);
        applyStimulus("rl8",  3'd5, 8'h00, 1'b0, 1'b0, 8'h6C);
        applyStimulus("rl8",  3'd5, 8'h00, 1'b0, 1'b0, 8'hD8);
        applyStimulus("rl8",  3'd5, 8'h00, 1'b0, 1'b0, 8'hB1);
        applyStimulus("rl8",  3'd5, 8'h00, 1'b0, 1'b0, 8'h63);
        applyStimulus("rl8",  3'd5, 8'h00, 1'b0, 1'b0, 8'hC6);
        applyStimulus("rl8",  3'd5, 8'h00, 1'b0, 1'b0, 8'h8D);
        applyStimulus("rl8",  3'd5, 8'h00, 1'b0, 1'b0, 8'h1B);

        applyStimulus("load", 3'd1, 8'hB3, 1'b0, 1'b0, 8'hB3);
        applyStimulus("asr1", 3'd6, 8'h00, 1'b0, 1'b1, 8'hD9);
        applyStimulus("asr2", 3'd6, 8'h00, 1'b0, 1'b1, 8'hEC);
        applyStimulus("load", 3'd1, 8'h4C, 1'b0, 1'b0, 8'h4C);
        applyStimulus("asrPos", 3'd6, 8'h00, 1'b1, 1'b1, 8'h26);
        applyStimulus("load", 3'd1, 8'hE9, 1'b0, 1'b0, 8'hE9);
        applyStimulus("asl", 3'd7, 8'hFF, 1'b1, 1'b1, 8'hD2);
        applyStimulus("asl", 3'd7, 8'hFF, 1'b1, 1'b1, 8'hA4);
        applyStimulus("asl", 3'd7, 8'hFF, 1'b1, 1'b1, 8'h48);
        applyStimulus("asl", 3'd7, 8'hFF, 1'b1, 1'b1, 8'h90);
        applyStimulus("asl", 3'd7, 8'hFF, 1'b1, 1'b1, 8'h20);
        applyStimulus("asl", 3'd7, 8'hFF, 1'b1, 1'b1, 8'h40);
        applyStimulus("asl", 3'd7, 8'hFF, 1'b1, 1'b1, 8'h80);
        applyStimulus("asl", 3'd7, 8'hFF, 1'b1, 1'b1, 8'h00);

        for (int i = 0; i < 24; i++) begin
            rop  = 3'($urandom_range(0, 7));
            rd   = 8'($urandom);
            rmsb = 1'($urandom);
            rlsb = 1'($urandom);
            applyStimulus("random", rop, rd, rmsb, rlsb, modelNext(modelQ, rop, rd, rmsb, rlsb));
        end
        applyStimulus("preClear", 3'd1, 8'hC3, 1'b0, 1'b0, 8'hC3);

        // Drop clear between edges; Q must go to zero before the next rise.
        #3 clear = 1'b0;
        #1 checkOutput("clearMidCycle", bus.Q, 8'h00);
        applyStimulus("clearHeld", 3'd1, 8'h77, 1'b1, 1'b1, 8'h00);
        applyStimulus("clearHeld", 3'd3, 8'h77, 1'b1, 1'b1, 8'h00);

        @(negedge clk);
        clear = 1'b1;
        applyStimulus("resume", 3'd1, 8'h5A, 1'b0, 1'b0, 8'h5A);
        applyStimulus("resume", 3'd3, 8'h00, 1'b1, 1'b0, 8'hB4);
        applyStimulus("resume", 3'd2, 8'h00, 1'b1, 1'b0, 8'hDA);

        waitCycles = 0;
        while (expQueue.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (expQueue.size() > 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d expected results left, required 0", expQueue.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
